ccff_chain_loader: RTL

//  Upstream feeder of the configuration-chain (ccff) head of routing/CB/SB tiles.

---
 rtl/ccff_loader_pkg.sv | 24 ++
 rtl/ccff_chain_loader.sv | 100 ++++++++++
 2 files changed

// File: rtl/ccff_loader_pkg.sv
// Shared types and helpers for the configuration-chain loader.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Number of bits of byte `byte_idx` that belong to a chain of `chain_len` bits.
    // Every byte carries 8 bits except a trailing partial byte.
    function automatic logic [3:0] bits_used(input int unsigned byte_idx,
                                             input int unsigned chain_len);
        int unsigned num_bytes;
        int unsigned rem;
        num_bytes = (chain_len + 7) / 8;
        rem       = chain_len % 8;
        if (byte_idx == num_bytes - 1 && rem != 0) begin
            return 4'(rem);
        end
        return 4'd8;
    endfunction

endpackage

// File: rtl/ccff_chain_loader.sv
// Serialises a byte-stream bitstream MSB-first onto the ccff chain head,
// with a per-bit clock enable for the fabric's prog_clk gate.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 15,
    parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic             prog_clk,
    input  logic             prog_reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [7:0]       cfg_data,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             ccff_head,
    output logic             ccff_clk_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bit_count
);

    localparam int unsigned NUM_BYTES = (CHAIN_LEN + 7) / 8;
    localparam int unsigned BYTE_W    = $clog2(NUM_BYTES + 1);

    state_t              state;
    state_t              state_next;
    logic [7:0]          sr;
    logic [3:0]          sr_cnt;
    logic [BYTE_W-1:0]   byte_cnt;
    logic [CNT_W-1:0]    bit_cnt;
    logic                accept;
    logic                last_bit;
    logic                load_start;

    // Outputs are decoded purely from registered state so the fabric
    // gate never sees a combinational path from the stream inputs.
    assign busy        = (state == SHIFT);
    assign done        = (state == DONE);
    assign ccff_clk_en = busy && (sr_cnt != 4'd0);
    assign ccff_head   = ccff_clk_en && sr[7];
    assign bit_count   = bit_cnt;

    // A new byte may land when the shifter is empty or is emitting its last bit,
    // which keeps back-to-back bytes bubble-free.
    assign cfg_ready = busy
                    && ((sr_cnt == 4'd0) || ((sr_cnt == 4'd1) && ccff_clk_en))
                    && (byte_cnt < BYTE_W'(NUM_BYTES));

    assign accept     = cfg_valid && cfg_ready;
    assign last_bit   = ccff_clk_en && (bit_cnt == CNT_W'(CHAIN_LEN - 1));
    assign load_start = start && (state != SHIFT);

    // State register.
    always_ff @(posedge prog_clk) begin
        if (!prog_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; abort overrides everything else.
    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start)    state_next = SHIFT;
                SHIFT:   if (last_bit) state_next = DONE;
                DONE:    if (start)    state_next = SHIFT;
                default:               state_next = IDLE;
            endcase
        end
    end

    // Shift register, bit counter and byte counter.
    always_ff @(posedge prog_clk) begin
        if (!prog_reset_n || abort || load_start) begin
            sr       <= '0;
            sr_cnt   <= '0;
            byte_cnt <= '0;
            bit_cnt  <= '0;
        end else if (busy) begin
            if (ccff_clk_en) begin
                sr      <= {sr[6:0], 1'b0};
                sr_cnt  <= sr_cnt - 4'd1;
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
            // A load on the last-bit cycle replaces the (now empty) shifter.
            if (accept) begin
                sr       <= cfg_data;
                sr_cnt   <= bits_used(32'(byte_cnt), CHAIN_LEN);
                byte_cnt <= byte_cnt + BYTE_W'(1);
            end
        end
    end

endmodule
